// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: registered FETCH/DECODE/EXEC/MEM/WB sequencer owning the PC, with illegal-opcode trap and retire-count halt.
module multicycle_ctrl #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 'h28,
    parameter int              MAX_INSTR = 0,
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      ins,
    input  logic             zero,
    input  logic [XLEN-1:0]  jTarget,
    input  logic [XLEN-1:0]  branch,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pcp4,
    output logic [31:0]      ir,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic [2:0]       op,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Mem2Reg,
    output logic             Link,
    output logic [2:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [XLEN-1:0]  r_pc, w_pc_nxt;
    logic [31:0]      r_ir;
    logic [CNT_W-1:0] r_retired, w_ret_inc;
    logic             r_illegal, w_retire, w_hit, w_active;
    logic             w_r, w_i, w_ld, w_st, w_beq, w_jal, w_legal;
    logic [2:0]       w_rop;

    assign w_r     = r_ir[6:0] == 7'h33;
    assign w_i     = r_ir[6:0] == 7'h13;
    assign w_ld    = r_ir[6:0] == 7'h03;
    assign w_st    = r_ir[6:0] == 7'h23;
    assign w_beq   = r_ir[6:0] == 7'h63;
    assign w_jal   = r_ir[6:0] == 7'h6F;
    assign w_legal = w_r | w_i | w_ld | w_st | w_beq | w_jal;

    assign pcp4      = r_pc + XLEN'(4);
    assign w_ret_inc = r_retired + CNT_W'(1);
    assign w_hit     = (MAX_INSTR != 0) && (w_ret_inc == CNT_W'(MAX_INSTR));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_retired <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (r_state == S_FETCH) r_ir <= ins;
            if (w_retire) r_retired <= w_ret_inc;
            if (r_state == S_DECODE && !w_legal) r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_retire    = 1'b0;
        w_pc_nxt    = r_pc;
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH:  w_state_nxt = S_DECODE;
            S_DECODE: w_state_nxt = w_legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                w_retire    = w_beq;
                w_pc_nxt    = w_beq ? (zero ? branch : pcp4) : r_pc;
                w_state_nxt = (w_ld || w_st) ? S_MEM : S_WB;
            end
            S_MEM: begin
                w_retire    = w_st;
                w_pc_nxt    = w_st ? pcp4 : r_pc;
                w_state_nxt = S_WB;
            end
            S_WB: begin
                w_retire = 1'b1;
                w_pc_nxt = w_jal ? jTarget : pcp4;
            end
            default: ;
        endcase
        if (w_retire) w_state_nxt = w_hit ? S_HALT : S_FETCH;
    end

    always_comb begin
        w_rop = 3'b010;
        case (r_ir[14:12])
            3'b000:  w_rop = r_ir[30] ? 3'b110 : 3'b010;
            3'b111:  w_rop = 3'b000;
            3'b110:  w_rop = 3'b001;
            3'b010:  w_rop = 3'b111;
            default: ;
        endcase
    end

    // op/ALUSrc stay at their EXEC values through MEM and WB so the ALU result remains stable
    assign w_active = r_state inside {S_EXEC, S_MEM, S_WB};
    assign op       = !w_active ? 3'b010 : w_r ? w_rop : w_beq ? 3'b110 : 3'b010;
    assign ALUSrc   = w_active && !(w_r || w_beq);
    assign MemRead  = r_state == S_MEM && w_ld;
    assign MemWrite = r_state == S_MEM && w_st;
    assign RegWrite = r_state == S_WB;
    assign Mem2Reg  = r_state == S_WB && w_ld;
    assign Link     = r_state == S_WB && w_jal;

    assign pc      = r_pc;
    assign ir      = r_ir;
    assign state   = r_state;
    assign halted  = r_state == S_HALT;
    assign illegal = r_illegal;
    assign retired = r_retired;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed and randomized instruction streams checked against a per-class phase/PC reference model.
module tb_multicycle_ctrl;
    localparam int MAXI = 11;

    logic        clk = 1'b0, rst_n = 1'b0, zero = 1'b0;
    logic [31:0] ins = '0, jTarget = '0, branch = '0;
    logic [31:0] pc, pcp4, ir;
    logic        RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, Link, halted, illegal;
    logic [2:0]  op, state;
    logic [15:0] retired;

    int          n_cmp = 0, n_err = 0;
    logic [31:0] m_pc;
    logic [15:0] m_ret;
    logic [6:0]  opc [6] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F};

    multicycle_ctrl #(.MAX_INSTR(MAXI)) dut (
        .clk(clk), .rst_n(rst_n), .ins(ins), .zero(zero), .jTarget(jTarget), .branch(branch),
        .pc(pc), .pcp4(pcp4), .ir(ir), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .op(op),
        .MemRead(MemRead), .MemWrite(MemWrite), .Mem2Reg(Mem2Reg), .Link(Link),
        .state(state), .halted(halted), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] ctl_now();
        return {RegWrite, ALUSrc, op, MemRead, MemWrite, Mem2Reg, Link};
    endfunction

    function automatic int classify(input logic [6:0] o);
        for (int k = 0; k < 6; k++) if (opc[k] == o) return k;
        return -1;
    endfunction

    // class: 0 R, 1 I-ALU, 2 load, 3 store, 4 beq, 5 JAL; phase numbers match the state encoding
    function automatic logic [8:0] ctl_exp(input int cls, input int ph, input logic [31:0] i);
        logic [2:0] o = 3'b010;
        logic       a = 1'b0;
        if (ph >= 2 && ph <= 4) begin
            a = !(cls == 0 || cls == 4);
            if (cls == 4) o = 3'b110;
            if (cls == 0) begin
                case (i[14:12])
                    3'b000:  o = i[30] ? 3'b110 : 3'b010;
                    3'b111:  o = 3'b000;
                    3'b110:  o = 3'b001;
                    3'b010:  o = 3'b111;
                    default: o = 3'b010;
                endcase
            end
        end
        return {ph == 4, a, o, ph == 3 && cls == 2, ph == 3 && cls == 3, ph == 4 && cls == 2, ph == 4 && cls == 5};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_pc", pc, 32'h28);
        chk("rst_ir", ir, 0);
        chk("rst_retired", retired, 0);
        chk("rst_flags", {halted, illegal}, 0);
        chk("rst_ctl", ctl_now(), 9'b0_0_010_0000);
        rst_n = 1'b1;
        m_pc  = 32'h28;
        m_ret = '0;
    endtask

    task automatic run_instr(input logic [31:0] i, input logic z, input logic [31:0] br, input logic [31:0] jt);
        int cls = classify(i[6:0]);
        int ph[$];
        case (cls)
            2:       ph = '{0, 1, 2, 3, 4};
            3:       ph = '{0, 1, 2, 3};
            4:       ph = '{0, 1, 2};
            default: ph = '{0, 1, 2, 4};
        endcase
        ins = i; zero = z; branch = br; jTarget = jt;
        foreach (ph[k]) begin
            chk("state", state, ph[k]);
            chk("ctl", ctl_now(), ctl_exp(cls, ph[k], i));
            chk("pc_hold", pc, m_pc);
            if (k == 1) chk("ir", ir, i);
            @(posedge clk);
            @(negedge clk);
        end
        m_pc = cls == 4 ? (z ? br : m_pc + 4) : cls == 5 ? jt : m_pc + 4;
        m_ret++;
        chk("pc_retire", pc, m_pc);
        chk("pcp4", pcp4, m_pc + 4);
        chk("retired", retired, m_ret);
        chk("post_state", state, m_ret == MAXI ? 7 : 0);
        chk("halted", halted, m_ret == MAXI);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        run_instr(32'h00500093, 1'b0, 32'h0, 32'h0);
        run_instr(32'h40208133, 1'b1, 32'h0, 32'h0);
        run_instr(32'h0000a103, 1'b0, 32'h0, 32'h0);
        run_instr(32'h0020a023, 1'b0, 32'h0, 32'h0);
        run_instr(32'h00208063, 1'b1, 32'h40, 32'h0);
        run_instr(32'h00208063, 1'b0, 32'h80, 32'h0);
        run_instr(32'h004000EF, 1'b0, 32'h0, 32'h100);

        ins = 32'h0000007F;
        @(posedge clk); @(negedge clk);
        chk("ill_decode", state, 1);
        @(posedge clk); @(negedge clk);
        chk("ill_state", state, 7);
        chk("ill_flags", {halted, illegal}, 2'b11);
        for (int k = 0; k < 10; k++) begin
            ins = $urandom;
            chk("halt_pc", pc, m_pc);
            chk("halt_ctl", {state, ctl_now()}, {3'd7, 9'b0_0_010_0000});
            @(posedge clk); @(negedge clk);
        end
        do_reset();

        for (int k = 0; k < MAXI; k++) run_instr(32'h00500093 | ($urandom & 32'hFFFFF000), 1'b0, 32'h0, 32'h0);
        chk("max_pc", pc, 32'h54);
        @(posedge clk); @(negedge clk);
        chk("max_frozen", {state, pc, retired}, {3'd7, 32'h54, 16'd11});
        do_reset();

        ins = 32'h0000a103;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        chk("mid_mem", {state, MemRead}, {3'd3, 1'b1});
        do_reset();
        @(posedge clk); @(negedge clk);
        chk("mid_after", {retired, RegWrite}, 17'd0);
        do_reset();

        for (int r = 0; r < 8; r++) begin
            int n = $urandom_range(1, 10);
            for (int k = 0; k < n; k++) begin
                logic [31:0] i = $urandom;
                i[6:0] = opc[$urandom_range(0, 5)];
                run_instr(i, 1'($urandom), $urandom & 32'hFFFFFFFC, $urandom & 32'hFFFFFFFC);
            end
            do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multi-cycle control sequencer for the RISC-V lab datapath. It owns the program counter, latches each fetched instruction, and walks it through FETCH/DECODE/EXEC/MEM/WB, driving `RegWrite`, `ALUSrc`, `op` and the memory and PC-select controls that `yIF`/`yID`/`yEX`/`yDM` consume. It replaces hand-driven per-instruction control and fixed repeat loops with a registered FSM. It adds load/store/branch/jump sequencing, an illegal-opcode trap and a retire-count halt.

## Interface
Parameters:
- `XLEN`, 32, PC / target width
- `RESET_PC`, 32'h28, PC value loaded at reset
- `MAX_INSTR`, 0, halt after this many retired instructions (0 = never)
- `CNT_W`, 16, width of retired-instruction counter

Ports:
- `clk` in 1: single clock, all state updates on rising edge
- `rst_n` in 1: synchronous, active-low reset
- `ins` in 32: instruction from `yIF`, valid during FETCH
- `zero` in 1: ALU zero flag from `yEX`, sampled in EXEC
- `jTarget` in XLEN: JAL target from `yID`
- `branch` in XLEN: branch target from `yID`
- `pc` out XLEN: current PC, feeds `yIF`
- `pcp4` out XLEN: `pc + 4`, combinational
- `ir` out 32: latched instruction, feeds `yID`
- `RegWrite` out 1, `ALUSrc` out 1, `op` out 3, `MemRead` out 1, `MemWrite` out 1, `Mem2Reg` out 1, `Link` out 1 (WB selects PC+4): datapath controls
- `state` out 3: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7
- `halted` out 1, `illegal` out 1: sticky status
- `retired` out CNT_W: retired-instruction count

## Operation
- Reset (`rst_n`=0 at edge): `pc`=RESET_PC, `ir`=0, `state`=FETCH, `retired`=0, `halted`=0, `illegal`=0. All control outputs are 0, except `op`=3'b010.
- FETCH: `ir` <= `ins`; next DECODE.
- DECODE: classify `ir[6:0]`:
  - 0x33 R: next EXEC
  - 0x13 I-ALU: next EXEC
  - 0x03 load: next EXEC
  - 0x23 store: next EXEC
  - 0x63 beq: next EXEC
  - 0x6F JAL: next EXEC
  - Any other opcode: next HALT with `illegal`=1.
- EXEC, `op` selection:
  - R-type: funct3 000 with `ir[30]`=0 gives 010 (add); with `ir[30]`=1 gives 110 (sub). 111 gives 000 (and), 110 gives 001 (or), 010 gives 111 (slt). Other funct3 values give 010.
  - beq: 110.
  - All other classes: 010.
- EXEC, `ALUSrc`: 0 for R-type and beq; 1 otherwise.
- EXEC, next state:
  - R, I-ALU, JAL go to WB.
  - Load and store go to MEM.
  - beq retires here: `pc` <= `zero` ? `branch` : `pc+4`; next FETCH.
- MEM: `MemRead`=1 for load, then next WB. `MemWrite`=1 for store; store retires here with `pc` <= `pc+4` and next FETCH.
- WB: `RegWrite`=1.
  - `Mem2Reg`=1 for load.
  - `Link`=1 for JAL, and `pc` <= `jTarget`.
  - All others: `pc` <= `pc+4`.
  - Retire, next FETCH.
- Retire: `retired` += 1 (wraps modulo 2^CNT_W). If `MAX_INSTR`≠0 and the new count equals `MAX_INSTR`, next state is HALT instead of FETCH.
- HALT: absorbing. `halted`=1, all controls deasserted, `pc` frozen. Left only by reset.
- `op` and `ALUSrc` are held with their EXEC values through MEM and WB, so the ALU result stays valid for writeback and addressing.
- Outside these phases, all controls are 0 (`op`=010).

## Timing
- Controls are Moore outputs, decoded from `state` and `ir` only. There is no combinational path from `ins`/`zero` to any control.
- Cycles per instruction:
  - R, I-ALU, JAL: 4
  - load: 5
  - store: 4
  - beq: 3
- `pc` changes only on the retiring edge. `ins` for the new PC is required valid by the next FETCH edge.
- Reset mid-instruction returns to FETCH at RESET_PC on the same edge. No partial retire or write occurs.
- `MAX_INSTR`=1: halts after the first retire. The retiring cycle's writes still complete.

## Test plan
- Reset, then addi x1,x0,5 (0x00500093) at 0x28 → FETCH, DECODE, EXEC, WB. `RegWrite`=1 only in WB with `ALUSrc`=1, `op`=010. `pc`=0x2C after 4 cycles; `retired`=1.
- sub (funct7 0x20, opcode 0x33) → `op`=110 and `ALUSrc`=0 in EXEC. lw → 5 cycles with `MemRead` in MEM and `Mem2Reg`+`RegWrite` in WB. sw → `MemWrite` in MEM, no `RegWrite`.
- beq with `zero`=1 and `branch`=0x40 → `pc`=0x40 after 3 cycles. Repeat with `zero`=0 → `pc`=pc+4.
- JAL with `jTarget`=0x100 → `Link`=1 and `RegWrite`=1 in WB, `pc`=0x100.
- Opcode 0x7F → HALT after DECODE with `illegal`=1 and `halted`=1. `pc` frozen for 10 cycles. `rst_n`=0 clears both flags and restores `pc`=0x28.
- `MAX_INSTR`=11 with a stream of addi → `halted` rises right after the 11th retire, with `retired`=11 and `pc`=0x28+44=0x54. Reset asserted during a load's MEM → no `RegWrite`, `retired` unchanged at 0.
